// File: rtl/guitar_effect_chain.sv
// guitar_effect_chain
// Avalon-MM sample processor: input sample FIFO -> 3-stage gain/clip
// distortion pipeline -> output sample FIFO, with sticky error flags,
// credit-based issue (the output FIFO can never overflow), a flush command
// and a programmable clip threshold.
// Optional feature: define GE_IRQ_EN to add the watermark interrupt
// (irq port, CTRL bit2, WATERMARK register, STATUS bit6).
module guitar_effect_chain #(
  parameter int DATA_W  = 24,
  parameter int FIFO_AW = 4,
  parameter int GAIN_W  = 16,
  parameter int FRAC_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  avl_address,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
`ifdef GE_IRQ_EN
  output logic        irq,
`endif
  output logic [31:0] avl_readdata
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  localparam int PW    = DATA_W + GAIN_W + 1;

  localparam logic [4:0] ADDR_CTRL   = 5'd0;
  localparam logic [4:0] ADDR_GAIN   = 5'd1;
  localparam logic [4:0] ADDR_CLIP   = 5'd2;
  localparam logic [4:0] ADDR_STATUS = 5'd3;
  localparam logic [4:0] ADDR_OUTPUT = 5'd5;
  localparam logic [4:0] ADDR_INPUT  = 5'd6;
  localparam logic [4:0] ADDR_FLUSH  = 5'd7;
`ifdef GE_IRQ_EN
  localparam logic [4:0] ADDR_WMARK  = 5'd8;
`endif

  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << FRAC_W);
  localparam logic [DATA_W-2:0] CLIP_MAX   = '1;

  // Configuration registers
  logic              bypass;
  logic              enable;
  logic [GAIN_W-1:0] gain;
  logic [DATA_W-2:0] clip;
`ifdef GE_IRQ_EN
  logic              irq_en;
  logic [LW-1:0]     watermark;
`endif

  // Sticky flags
  logic in_overflow;
  logic out_underflow;

  // Input FIFO
  logic [DATA_W-1:0]  in_mem [DEPTH];
  logic [FIFO_AW-1:0] in_wp, in_rp;
  logic [LW-1:0]      in_level, in_level_nxt;
  logic               in_empty, in_full;
  logic [DATA_W-1:0]  in_head;

  // Output FIFO
  logic [DATA_W-1:0]  out_mem [DEPTH];
  logic [FIFO_AW-1:0] out_wp, out_rp;
  logic [LW-1:0]      out_level, out_level_nxt;
  logic               out_empty, out_full;
  logic [DATA_W-1:0]  out_head;

  // Pipeline
  logic               s1_valid, s1_byp;
  logic [DATA_W-1:0]  s1_data;
  logic               s2_valid, s2_byp;
  logic signed [PW-1:0] s2_val;
  logic signed [PW-1:0] s1_ext, gain_ext, product, scaled;
  logic signed [PW-1:0] clip_pos, clip_neg, sat_val;
  logic [DATA_W-1:0]  s3_data;

  // Bus decode and datapath handshakes
  logic wr_ctrl, wr_gain, wr_clip, wr_status, wr_input, flush;
  logic rd_output;
  logic in_push, in_pop, in_drop;
  logic out_push, out_pop, out_under;
  logic issue;
  logic [LW:0] occupancy;
  logic [31:0] status, rd_data;
  logic [7:0]  in_level8, out_level8;
  logic        unused_bits;

  assign unused_bits = ^avl_writedata;

  assign wr_ctrl   = avl_write && (avl_address == ADDR_CTRL);
  assign wr_gain   = avl_write && (avl_address == ADDR_GAIN);
  assign wr_clip   = avl_write && (avl_address == ADDR_CLIP);
  assign wr_status = avl_write && (avl_address == ADDR_STATUS);
  assign wr_input  = avl_write && (avl_address == ADDR_INPUT);
  assign flush     = avl_write && (avl_address == ADDR_FLUSH);
  assign rd_output = avl_read  && (avl_address == ADDR_OUTPUT);

  assign in_empty  = (in_level == '0);
  assign in_full   = (in_level == LW'(DEPTH));
  assign out_empty = (out_level == '0);
  assign out_full  = (out_level == LW'(DEPTH));
  assign in_head   = in_mem[in_rp];
  assign out_head  = out_mem[out_rp];

  // Credit check: every sample in flight already owns an output FIFO slot,
  // so stage 3 can always push without looking at out_full.
  assign occupancy = {1'b0, out_level} + (LW+1)'(s1_valid) + (LW+1)'(s2_valid);
  assign issue     = enable && !in_empty && (occupancy < (LW+1)'(DEPTH)) && !flush;

  assign in_push   = wr_input && !in_full && !flush;
  assign in_drop   = wr_input && in_full;
  assign in_pop    = issue;
  assign out_push  = s2_valid && !flush;
  assign out_pop   = rd_output && !out_empty;
  assign out_under = rd_output && out_empty;

  // Next FIFO levels; flush wins over any concurrent push or pop
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    in_level_nxt  = in_level;
    out_level_nxt = out_level;
    if (flush) begin
      in_level_nxt  = '0;
      out_level_nxt = '0;
    end else begin
      if (in_push && !in_pop)       in_level_nxt  = in_level + 1'b1;
      else if (!in_push && in_pop)  in_level_nxt  = in_level - 1'b1;
      if (out_push && !out_pop)     out_level_nxt = out_level + 1'b1;
      else if (!out_push && out_pop) out_level_nxt = out_level - 1'b1;
    end
  end

  // FIFO storage arrays
  always_ff @(posedge clk) begin
    // NOTE: sample storage has no reset; the pointers and levels define which
    // entries are valid, so clearing the array would only cost reset fan-out.
    if (in_push)  in_mem[in_wp]   <= avl_writedata[DATA_W-1:0];
    if (out_push) out_mem[out_wp] <= s3_data;
  end

  // FIFO pointers and levels
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      in_wp     <= '0;
      in_rp     <= '0;
      in_level  <= '0;
      out_wp    <= '0;
      out_rp    <= '0;
      out_level <= '0;
    end else if (flush) begin
      in_wp     <= '0;
      in_rp     <= '0;
      in_level  <= '0;
      out_wp    <= '0;
      out_rp    <= '0;
      out_level <= '0;
    end else begin
      if (in_push)  in_wp  <= in_wp + 1'b1;
      if (in_pop)   in_rp  <= in_rp + 1'b1;
      if (out_push) out_wp <= out_wp + 1'b1;
      if (out_pop)  out_rp <= out_rp + 1'b1;
      in_level  <= in_level_nxt;
      out_level <= out_level_nxt;
    end
  end

  // Configuration registers (retained across flush)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bypass <= 1'b1;
      enable <= 1'b0;
      gain   <= GAIN_UNITY;
      clip   <= CLIP_MAX;
    end else begin
      if (wr_ctrl) begin
        bypass <= avl_writedata[0];
        enable <= avl_writedata[1];
      end
      if (wr_gain) gain <= avl_writedata[GAIN_W-1:0];
      if (wr_clip) clip <= avl_writedata[DATA_W-2:0];
    end
  end

`ifdef GE_IRQ_EN
  // Interrupt configuration and registered watermark interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en    <= 1'b0;
      watermark <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= avl_writedata[2];
      if (avl_write && (avl_address == ADDR_WMARK)) watermark <= avl_writedata[LW-1:0];
      irq <= irq_en && (watermark != '0) && (out_level_nxt >= watermark);
    end
  end
`endif

  // Sticky error flags: write-1-to-clear, a new error in the same cycle wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_overflow   <= 1'b0;
      out_underflow <= 1'b0;
    end else if (flush) begin
      in_overflow   <= 1'b0;
      out_underflow <= 1'b0;
    end else begin
      if (in_drop)                            in_overflow   <= 1'b1;
      else if (wr_status && avl_writedata[4]) in_overflow   <= 1'b0;
      if (out_under)                          out_underflow <= 1'b1;
      else if (wr_status && avl_writedata[5]) out_underflow <= 1'b0;
    end
  end

  // Stage 2 arithmetic: signed sample times unsigned gain, then floor-scale
  always_comb begin
    s1_ext   = {{(PW-DATA_W){s1_data[DATA_W-1]}}, s1_data};
    gain_ext = {{(PW-GAIN_W){1'b0}}, gain};
    product  = s1_ext * gain_ext;
    scaled   = product >>> FRAC_W;
  end

  // Stage 3 saturation; clip is DATA_W-1 bits wide, so it can never exceed
  // the largest positive sample and needs no further limiting.
  always_comb begin
    clip_pos = {{(PW-DATA_W+1){1'b0}}, clip};
    clip_neg = -clip_pos;
    sat_val  = s2_val;
    if (s2_val > clip_pos)      sat_val = clip_pos;
    else if (s2_val < clip_neg) sat_val = clip_neg;
    s3_data  = s2_byp ? s2_val[DATA_W-1:0] : sat_val[DATA_W-1:0];
  end

  // Pipeline stages 1 and 2; flush kills everything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_byp   <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_byp   <= 1'b0;
      s2_val   <= '0;
    end else begin
      s1_valid <= issue;
      s1_byp   <= bypass;
      s1_data  <= in_head;
      s2_valid <= s1_valid && !flush;
      s2_byp   <= s1_byp;
      s2_val   <= s1_byp ? s1_ext : scaled;
    end
  end

  // STATUS word assembly
  always_comb begin
    in_level8     = 8'(in_level);
    out_level8    = 8'(out_level);
    status        = '0;
    status[0]     = in_empty;
    status[1]     = in_full;
    status[2]     = out_empty;
    status[3]     = out_full;
    status[4]     = in_overflow;
    status[5]     = out_underflow;
`ifdef GE_IRQ_EN
    status[6]     = irq;
`endif
    status[14:8]  = in_level8[6:0];
    status[22:16] = out_level8[6:0];
  end

  // Read data mux
  always_comb begin
    rd_data = '0;
    case (avl_address)
      ADDR_CTRL: begin
        rd_data[0] = bypass;
        rd_data[1] = enable;
`ifdef GE_IRQ_EN
        rd_data[2] = irq_en;
`endif
      end
      ADDR_GAIN:   rd_data = 32'(gain);
      ADDR_CLIP:   rd_data = 32'(clip);
      ADDR_STATUS: rd_data = status;
      ADDR_OUTPUT: rd_data = out_empty ? 32'd0 : 32'($signed(out_head));
`ifdef GE_IRQ_EN
      ADDR_WMARK:  rd_data = 32'(watermark);
`endif
      default:     rd_data = '0;
    endcase
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        avl_readdata <= '0;
    else if (avl_read) avl_readdata <= rd_data;
  end

endmodule
